// File: rtl/de_write_buffer_pkg.sv
// rtl/de_write_buffer_pkg.sv - shared types, constants and lane-merge helper for the write buffer
package de_write_buffer_pkg;

  localparam int         DATA_W     = 32;
  localparam int         WB_ADDR_W  = 18;
  localparam logic [3:0] NBYTE_NONE = 4'b1111;

  // One buffered write: word address, active-low byte enables, data
  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [3:0]           nbyte;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

  // Lanes enabled (low) in nbyte take new_data, the rest keep old_data
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [3:0]        nbyte,
                                                    input logic [DATA_W-1:0] old_data,
                                                    input logic [DATA_W-1:0] new_data);
    logic [DATA_W-1:0] merged;
    merged = old_data;
    for (int i = 0; i < 4; i++) begin
      if (!nbyte[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/de_wbuf_fifo.sv
// rtl/de_wbuf_fifo.sv - synchronous FIFO holding combined writes awaiting the memory port
module de_wbuf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 54
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal when a pop frees a slot on the same edge
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Entry storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/de_write_buffer.sv
// rtl/de_write_buffer.sv - write-combining posted-write buffer between draw engine and frame store
module de_write_buffer
  import de_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_req,
  output logic              de_ack,
  input  logic [ADDR_W-1:0] de_addr,
  input  logic [3:0]        de_nbyte,
  input  logic              de_rnw,
  input  logic [DATA_W-1:0] de_w_data,
  output logic [DATA_W-1:0] de_r_data,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_nbyte,
  output logic              mem_rnw,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic              empty
);

  localparam int ENTRY_W = ADDR_W + 4 + DATA_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} drain_state_e;

  drain_state_e      st_q, st_d;
  logic              c_valid_q, c_valid_d;
  logic [ADDR_W-1:0] c_addr_q, c_addr_d;
  logic [3:0]        c_nbyte_q, c_nbyte_d;
  logic [DATA_W-1:0] c_data_q, c_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_nbyte_q, mem_nbyte_d;
  logic              mem_rnw_q, mem_rnw_d;
  logic [DATA_W-1:0] mem_w_data_q, mem_w_data_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty, can_push;
  logic [ENTRY_W-1:0] fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               wr_ack, rd_ack;

  assign mem_req    = (st_q != ST_IDLE);
  assign mem_addr   = mem_addr_q;
  assign mem_nbyte  = mem_nbyte_q;
  assign mem_rnw    = mem_rnw_q;
  assign mem_w_data = mem_w_data_q;
  assign de_r_data  = mem_r_data;
  assign de_ack     = wr_ack | rd_ack;

  assign fifo_pop = (st_q == ST_WR) && mem_ack;
  assign can_push = !fifo_full || fifo_pop;
  assign empty    = !c_valid_q && (fifo_count == '0) && !(mem_req && !mem_rnw_q);

  de_wbuf_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  ({c_addr_q, c_nbyte_q, c_data_q}),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Combine register: merge same-word writes, evict on mismatch or idle cycle
  always_comb begin
    c_valid_d = c_valid_q;
    c_addr_d  = c_addr_q;
    c_nbyte_d = c_nbyte_q;
    c_data_d  = c_data_q;
    fifo_push = 1'b0;
    wr_ack    = 1'b0;
    if (de_req && !de_rnw) begin
      if (de_nbyte == NBYTE_NONE) begin
        wr_ack = 1'b1;
      end else if (c_valid_q && (de_addr == c_addr_q)) begin
        c_nbyte_d = c_nbyte_q & de_nbyte;
        c_data_d  = merge_lanes(de_nbyte, c_data_q, de_w_data);
        wr_ack    = 1'b1;
      end else if (!c_valid_q || can_push) begin
        fifo_push = c_valid_q;
        c_valid_d = 1'b1;
        c_addr_d  = de_addr;
        c_nbyte_d = de_nbyte;
        c_data_d  = merge_lanes(de_nbyte, '0, de_w_data);
        wr_ack    = 1'b1;
      end
    end else if (c_valid_q && can_push) begin
      fifo_push = 1'b1;
      c_valid_d = 1'b0;
    end
  end

  // Drain FSM: queued writes first, reads only once nothing is buffered
  always_comb begin
    st_d         = st_q;
    mem_addr_d   = mem_addr_q;
    mem_nbyte_d  = mem_nbyte_q;
    mem_rnw_d    = mem_rnw_q;
    mem_w_data_d = mem_w_data_q;
    rd_ack       = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          st_d         = ST_WR;
          mem_rnw_d    = 1'b0;
          mem_addr_d   = fifo_head[ENTRY_W-1 -: ADDR_W];
          mem_nbyte_d  = fifo_head[DATA_W +: 4];
          mem_w_data_d = fifo_head[DATA_W-1:0];
        end else if (de_req && de_rnw && empty) begin
          st_d        = ST_RD;
          mem_rnw_d   = 1'b1;
          mem_addr_d  = de_addr;
          mem_nbyte_d = de_nbyte;
        end
      end
      ST_WR: if (mem_ack) st_d = ST_IDLE;
      ST_RD: begin
        if (mem_ack) begin
          st_d   = ST_IDLE;
          rd_ack = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops everything buffered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= ST_IDLE;
      c_valid_q    <= 1'b0;
      c_addr_q     <= '0;
      c_nbyte_q    <= NBYTE_NONE;
      c_data_q     <= '0;
      mem_addr_q   <= '0;
      mem_nbyte_q  <= NBYTE_NONE;
      mem_rnw_q    <= 1'b0;
      mem_w_data_q <= '0;
    end else begin
      st_q         <= st_d;
      c_valid_q    <= c_valid_d;
      c_addr_q     <= c_addr_d;
      c_nbyte_q    <= c_nbyte_d;
      c_data_q     <= c_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_nbyte_q  <= mem_nbyte_d;
      mem_rnw_q    <= mem_rnw_d;
      mem_w_data_q <= mem_w_data_d;
    end
  end

endmodule

// File: tb/tb_de_write_buffer.sv
// tb/tb_de_write_buffer.sv - self-checking bench for de_write_buffer
module tb_de_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              de_req = 1'b0;
  logic              de_ack;
  logic [ADDR_W-1:0] de_addr = '0;
  logic [3:0]        de_nbyte = 4'hF;
  logic              de_rnw = 1'b0;
  logic [31:0]       de_w_data = '0;
  logic [31:0]       de_r_data;
  logic              mem_req;
  logic              mem_ack = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_nbyte;
  logic              mem_rnw;
  logic [31:0]       mem_w_data;
  logic [31:0]       mem_r_data = '0;
  logic              empty;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        nbyte;
    logic [31:0]       data;
    logic              rnw;
  } xfer_t;

  xfer_t       got_q[$];
  xfer_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          hold = 1'b1;
  bit          force_ack = 1'b0;
  bit          run_open = 1'b0;
  logic [31:0] last_rdata = '0;

  de_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .de_req     (de_req),
    .de_ack     (de_ack),
    .de_addr    (de_addr),
    .de_nbyte   (de_nbyte),
    .de_rnw     (de_rnw),
    .de_w_data  (de_w_data),
    .de_r_data  (de_r_data),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_addr   (mem_addr),
    .mem_nbyte  (mem_nbyte),
    .mem_rnw    (mem_rnw),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  // Memory responder: one-cycle ack pulses, logs every transfer it completes
  always @(negedge clk) begin
    if (mem_req === 1'b1 && !mem_ack && (hold ? force_ack : ($urandom_range(0, 2) != 0))) begin
      mem_ack = 1'b1;
      if (mem_rnw) begin
        last_rdata = $urandom;
        mem_r_data = last_rdata;
      end
      got_q.push_back('{mem_addr, mem_nbyte, (mem_rnw ? last_rdata : mem_w_data), mem_rnw});
    end else begin
      mem_ack = 1'b0;
    end
  end

  function automatic logic [31:0] lane_mask(input logic [3:0] nb);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (!nb[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  // Reference: consecutive accepted writes to one word form a single word write
  function automatic void model_write(input logic [ADDR_W-1:0] a, input logic [3:0] nb, input logic [31:0] d);
    logic [31:0] m;
    xfer_t       e;
    if (nb == 4'hF) return;
    m = lane_mask(nb);
    if (run_open && exp_q.size() > 0 && exp_q[$].addr == a && !exp_q[$].rnw) begin
      e = exp_q.pop_back();
      e.nbyte = e.nbyte & nb;
      e.data  = (e.data & ~m) | (d & m);
      exp_q.push_back(e);
    end else begin
      exp_q.push_back('{a, nb, d & m, 1'b0});
    end
    run_open = 1'b1;
  endfunction

  task automatic de_write(input logic [ADDR_W-1:0] a, input logic [3:0] nb, input logic [31:0] d,
                          input int max_wait, output bit ok, output int waited);
    @(negedge clk);
    de_req = 1'b1; de_rnw = 1'b0; de_addr = a; de_nbyte = nb; de_w_data = d;
    ok = 1'b0;
    waited = 0;
    while (1) begin
      #4;
      ok = (de_ack === 1'b1);
      @(posedge clk);
      if (ok || waited >= max_wait) break;
      waited++;
      @(negedge clk);
    end
    if (ok) model_write(a, nb, d);
  endtask

  task automatic de_read(input logic [ADDR_W-1:0] a, input logic [3:0] nb, input int max_wait,
                         output bit ok, output int waited, output logic [31:0] rd);
    @(negedge clk);
    de_req = 1'b1; de_rnw = 1'b1; de_addr = a; de_nbyte = nb;
    ok = 1'b0;
    waited = 0;
    rd = '0;
    while (1) begin
      #4;
      ok = (de_ack === 1'b1);
      rd = de_r_data;
      @(posedge clk);
      if (ok || waited >= max_wait) break;
      waited++;
      @(negedge clk);
    end
    if (ok) exp_q.push_back('{a, nb, 32'h0, 1'b1});
    run_open = 1'b0;
  endtask

  task automatic de_idle(input int n);
    @(negedge clk);
    de_req = 1'b0;
    de_rnw = 1'b0;
    run_open = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(empty === 1'b1 && mem_req === 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_drain empty=%b mem_req=%b required empty=1 mem_req=0", name, empty, mem_req);
    end
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
    run_open = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({mem_req, mem_rnw, mem_nbyte, empty, de_ack} !== 8'b00111110) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b rnw=%b nbyte=%b empty=%b ack=%b required 0 0 1111 1 0",
               mem_req, mem_rnw, mem_nbyte, empty, de_ack);
    end
    checks++;
    if (mem_addr !== '0 || mem_w_data !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h data=%h required 0 0", mem_addr, mem_w_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hold = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_combine();
    bit ok;
    int w;
    clear_q();
    for (int i = 0; i < 4; i++) begin
      de_write(18'h00010, ~(4'b0001 << i), {4{8'h11 * 8'(i + 1)}}, 0, ok, w);
      checks++;
      if (!ok) begin errors++; $display("FAIL combine_ack[%0d] ack=0 required 1", i); end
    end
    de_idle(1);
    wait_drain("combine");
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL combine_count got=%0d required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].addr !== 18'h00010 || got_q[0].nbyte !== 4'b0000 || got_q[0].data !== 32'h44332211 || got_q[0].rnw !== 1'b0) begin
        errors++;
        $display("FAIL combine_word got=%h/%b/%h/%b required 00010/0000/44332211/0",
                 got_q[0].addr, got_q[0].nbyte, got_q[0].data, got_q[0].rnw);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int w;
    logic [31:0] m;
    logic [ADDR_W-1:0] a;
    logic [3:0] nb;
    logic [31:0] d;
    clear_q();
    hold = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a  = (i % 2 == 1) ? 18'h2 : 18'h1;
      nb = 4'($urandom_range(0, 14));
      d  = $urandom;
      if (i < 5) begin
        de_write(a, nb, d, 0, ok, w);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_fill[%0d] ack=0 required 1", i); end
      end else begin
        if (i == 5) begin
          de_write(a, nb, d, 8, ok, w);
          checks++;
          if (ok) begin errors++; $display("FAIL stall_full ack=1 after %0d waits required stall", w); end
          hold = 1'b0;
        end
        de_write(a, nb, d, 200, ok, w);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_resume[%0d] ack=0 required 1", i); end
      end
    end
    de_idle(1);
    wait_drain("stall");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_count got=%0d required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      m = exp_q[i].rnw ? 32'h0 : lane_mask(exp_q[i].nbyte);
      checks++;
      if (got_q[i].addr !== exp_q[i].addr || got_q[i].nbyte !== exp_q[i].nbyte ||
          got_q[i].rnw !== exp_q[i].rnw || (got_q[i].data & m) !== (exp_q[i].data & m)) begin
        errors++;
        $display("FAIL stall_xfer[%0d] got=%h/%b/%h required %h/%b/%h", i, got_q[i].addr,
                 got_q[i].nbyte, got_q[i].data, exp_q[i].addr, exp_q[i].nbyte, exp_q[i].data);
      end
    end
  endtask

  task automatic test_raw();
    bit ok;
    int w;
    logic [31:0] rd;
    logic [31:0] m;
    clear_q();
    de_write(18'h5, 4'b1110, 32'h000000AA, 50, ok, w);
    checks++;
    if (!ok) begin errors++; $display("FAIL raw_write ack=0 required 1"); end
    de_read(18'h5, 4'b0000, 200, ok, w, rd);
    checks++;
    if (!ok || w < 3) begin errors++; $display("FAIL raw_read_wait ok=%0d waits=%0d required ok=1 waits>=3", ok, w); end
    checks++;
    if (rd !== last_rdata) begin errors++; $display("FAIL raw_rdata got=%h required %h", rd, last_rdata); end
    de_idle(1);
    wait_drain("raw");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL raw_count got=%0d required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      m = exp_q[i].rnw ? 32'h0 : lane_mask(exp_q[i].nbyte);
      checks++;
      if (got_q[i].addr !== exp_q[i].addr || got_q[i].nbyte !== exp_q[i].nbyte ||
          got_q[i].rnw !== exp_q[i].rnw || (got_q[i].data & m) !== (exp_q[i].data & m)) begin
        errors++;
        $display("FAIL raw_xfer[%0d] got=%h/%b/%h/%b required %h/%b/%h/%b", i, got_q[i].addr, got_q[i].nbyte,
                 got_q[i].data, got_q[i].rnw, exp_q[i].addr, exp_q[i].nbyte, exp_q[i].data, exp_q[i].rnw);
      end
    end
  endtask

  task automatic test_discard();
    bit ok;
    int w;
    bit bad;
    clear_q();
    de_write(18'h33, 4'b1111, $urandom, 0, ok, w);
    checks++;
    if (!ok) begin errors++; $display("FAIL discard_ack ack=0 required 1"); end
    de_idle(0);
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (empty !== 1'b1 || mem_req !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || got_q.size() != 0) begin
      errors++;
      $display("FAIL discard_idle empty=%b transfers=%0d required empty=1 transfers=0", empty, got_q.size());
    end
  endtask

  task automatic test_full_pushpop();
    bit ok;
    int w;
    logic [31:0] m;
    clear_q();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      de_write(18'h40 + 18'(i % 2), 4'($urandom_range(0, 14)), $urandom, 0, ok, w);
      checks++;
      if (!ok) begin errors++; $display("FAIL full_fill[%0d] ack=0 required 1", i); end
    end
    #1;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL full_memreq got=%b required 1", mem_req); end
    force_ack = 1'b1;
    de_write(18'h42, 4'($urandom_range(0, 14)), $urandom, 0, ok, w);
    force_ack = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL full_pushpop ack=0 required 1"); end
    de_write(18'h43, 4'($urandom_range(0, 14)), $urandom, 6, ok, w);
    checks++;
    if (ok) begin errors++; $display("FAIL full_count_kept ack=1 required stall"); end
    hold = 1'b0;
    de_write(de_addr, de_nbyte, de_w_data, 200, ok, w);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_resume ack=0 required 1"); end
    de_idle(1);
    wait_drain("full");
    checks++;
    if (got_q.size() != 7 || exp_q.size() != 7) begin
      errors++;
      $display("FAIL full_count got=%0d model=%0d required 7", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      m = exp_q[i].rnw ? 32'h0 : lane_mask(exp_q[i].nbyte);
      checks++;
      if (got_q[i].addr !== exp_q[i].addr || got_q[i].nbyte !== exp_q[i].nbyte ||
          got_q[i].rnw !== exp_q[i].rnw || (got_q[i].data & m) !== (exp_q[i].data & m)) begin
        errors++;
        $display("FAIL full_xfer[%0d] got=%h/%b/%h required %h/%b/%h", i, got_q[i].addr,
                 got_q[i].nbyte, got_q[i].data, exp_q[i].addr, exp_q[i].nbyte, exp_q[i].data);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int w;
    int n;
    clear_q();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) de_write(18'h50 + 18'(i), 4'b0000, $urandom, 0, ok, w);
    de_idle(1);
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin @(posedge clk); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL rstmid_memreq got=%b required 1", mem_req); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async mem_req=%b empty=%b required 0 1", mem_req, empty);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hold = 1'b0;
    clear_q();
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 0 || mem_req !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_stale transfers=%0d mem_req=%b empty=%b required 0 0 1", got_q.size(), mem_req, empty);
    end
  endtask

  task automatic test_random();
    bit ok;
    int w;
    logic [31:0] rd;
    logic [31:0] m;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] last_real;
    logic [3:0] nb;
    logic [31:0] d;
    bit dead;
    clear_q();
    dead = 1'b0;
    last_real = 18'h100;
    for (int k = 0; k < 80 && !dead; k++) begin
      a  = ($urandom_range(0, 1) == 0) ? last_real : 18'h100 + 18'($urandom_range(0, 3));
      nb = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      d  = $urandom;
      if (nb != 4'hF && a != last_real && $urandom_range(0, 3) == 0) de_idle(int'($urandom_range(1, 4)));
      de_write(a, nb, d, 200, ok, w);
      checks++;
      if (!ok) begin errors++; dead = 1'b1; $display("FAIL rand_write[%0d] ack=0 required 1", k); end
      if (nb != 4'hF) last_real = a;
    end
    if (!dead) begin
      de_read(18'h101, 4'b0000, 300, ok, w, rd);
      checks++;
      if (!ok || rd !== last_rdata) begin
        errors++;
        $display("FAIL rand_read ok=%0d data=%h required ok=1 data=%h", ok, rd, last_rdata);
      end
    end
    de_idle(1);
    wait_drain("rand");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count got=%0d required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      m = exp_q[i].rnw ? 32'h0 : lane_mask(exp_q[i].nbyte);
      checks++;
      if (got_q[i].addr !== exp_q[i].addr || got_q[i].nbyte !== exp_q[i].nbyte ||
          got_q[i].rnw !== exp_q[i].rnw || (got_q[i].data & m) !== (exp_q[i].data & m)) begin
        errors++;
        $display("FAIL rand_xfer[%0d] got=%h/%b/%h/%b required %h/%b/%h/%b", i, got_q[i].addr, got_q[i].nbyte,
                 got_q[i].data, got_q[i].rnw, exp_q[i].addr, exp_q[i].nbyte, exp_q[i].data, exp_q[i].rnw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_combine();
    test_stall();
    test_raw();
    test_discard();
    test_full_pushpop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
